noc_output_data_tx: RTL and testbench
=====================================

Name: noc_output_data_tx

Overview:
- Avalon-MM slave (s1) in the Nios system that carries 32-bit words from the CPU onto the NoC link.
- Transmit-side counterpart of the NoC input-data port.
- CPU writes words into a small FIFO; a registered valid/ready output stage delivers them to the NoC router.
- Status and control registers let software poll occupancy and overflow, enable or disable transmission, and flush the FIFO.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_data  out  32  NoC word
- out_valid  out  1  NoC word valid
- out_ready  in  1  router accepts word

Behaviour:
- Reset state: readdata=0, out_data=0, out_valid=0, FIFO empty (count=0), overflow=0, enable=1.
- Register map:
  - 0 TXDATA: write pushes writedata; reads 0.
  - 1 STATUS (read): [0] empty, [1] full, [2] overflow (sticky), [3] out_valid, [8+CNT_W-1:8] count, other bits 0.
  - Writing 1 to STATUS[2] clears overflow; other STATUS bits ignore writes.
  - 2 CONTROL: [0] enable (R/W); [1] flush (write-1 pulse, reads 0).
  - 3: reserved, reads 0, writes ignored.
- Write qualifier: a write occurs when chipselect && !write_n. No wait states.
- readdata:
  - Registered every clk from the address mux, so latency is 1 cycle.
  - Reads have no side effects.
- Push:
  - A write to TXDATA with full=0 stores the word at wr_ptr and increments count.
  - full is evaluated before any same-cycle pop. A write to TXDATA while full drops the word and sets overflow, even if a pop occurs that cycle.
- Output stage:
  - load = enable && !empty && (!out_valid || out_ready).
  - On load, out_data <= FIFO head, rd_ptr advances, out_valid <= 1.
  - Else if out_ready, out_valid <= 0.
  - The first word reaches out_valid 1 cycle after the push cycle.
  - Sustained throughput is 1 word/clk while out_ready=1.
- Handshake rule: once out_valid=1, out_data and out_valid hold stable until the cycle out_ready=1. A beat is never retracted by disable, flush or overflow.
- Disable (enable=0): no new loads; a pending beat completes normally; the FIFO keeps accepting pushes.
- Simultaneous push and pop (not full): count unchanged; pointers both advance.
- Pointers: wrap modulo DEPTH; count ranges 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- Flush:
  - rd_ptr=wr_ptr=0 and count=0 next cycle.
  - Load is suppressed in the flush cycle.
  - The output register beat is unaffected.
  - overflow and enable are unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and out_valid drops. The router must treat a reset as a link reset.
- Write to CONTROL setting enable=1 and flush=1 together: both take effect; the FIFO is empty afterwards.

Decomposition:
- Package noc_tx_pkg holds:
  - register address constants TXDATA_ADDR=0, STATUS_ADDR=1, CONTROL_ADDR=2;
  - STATUS bit indices ST_EMPTY, ST_FULL, ST_OVF, ST_BUSY, ST_CNT_LSB=8;
  - CONTROL bit indices CT_EN, CT_FLUSH.
- One sub-module, noc_tx_fifo:
  - synchronous FIFO with ports push, pop, flush, din, dout, count, full, empty;
  - parameterised by DEPTH.
- Top level keeps the Avalon decode, overflow/enable registers and the output stage.

Test Plan:
- Reset; read STATUS -> readdata=0x0000_0001 one cycle after address presented; out_valid=0.
- out_ready=1; write 0xA5A5_0001 to addr 0 -> out_valid=1 with out_data=0xA5A5_0001 next cycle, then out_valid=0 the following cycle.
- out_ready=0; write 9 words 0x100..0x108 (DEPTH=8) ->
  - first word sits in output register, count=8, ninth word accepted, no overflow;
  - a tenth write sets STATUS[2];
  - out_data stays 0x100 throughout.
- From that full state, raise out_ready=1 -> words 0x100..0x108 emitted on consecutive cycles in order; STATUS ends 0x0000_0005 (empty+overflow); write 0x4 to STATUS -> overflow clears.
- Write CONTROL=0 then push 3 words -> out_valid stays 0, count=3. Write CONTROL=1 -> words stream out.
- Push 4 words with out_ready=0, write CONTROL=0x3 -> count=0, pending out_data unchanged and still valid until out_ready=1.
- Assert reset_n=0 mid-stream -> out_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/noc_tx_pkg.sv
// Register map and bit positions shared by the NoC transmit port and its FIFO.
package noc_tx_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_RSVD    = 2'd3
  } reg_addr_e;

  localparam reg_addr_e TXDATA_ADDR  = REG_TXDATA;
  localparam reg_addr_e STATUS_ADDR  = REG_STATUS;
  localparam reg_addr_e CONTROL_ADDR = REG_CONTROL;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CT_EN    = 0;
  localparam int CT_FLUSH = 1;

endpackage

// File: rtl/noc_tx_fifo.sv
// Synchronous FIFO holding CPU words until the output stage takes them.
// A push is accepted only when not full at the start of the cycle; flush wins over both ends.
module noc_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_output_data_tx.sv
// Avalon-MM slave that queues CPU words and presents them on a valid/ready NoC link.
// Holds register decode, sticky overflow, enable, and the registered output beat.
module noc_output_data_tx
  import noc_tx_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [31:0]      r_readdata;
  logic [31:0]      r_out_data;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_enable;

  logic             w_wr;
  logic             w_push;
  logic             w_flush;
  logic             w_load;
  logic             w_ovf_clr;
  logic [31:0]      w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_rdata;

  assign w_wr      = chipselect && !write_n;
  assign w_push    = w_wr && (address == TXDATA_ADDR);
  assign w_ovf_clr = w_wr && (address == STATUS_ADDR) && writedata[ST_OVF];
  assign w_flush   = w_wr && (address == CONTROL_ADDR) && writedata[CT_FLUSH];
  assign w_load    = r_enable && !w_empty && (!r_out_valid || out_ready) && !w_flush;

  noc_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_load),
    .flush   (w_flush),
    .din     (writedata),
    .dout    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_comb begin
    w_rdata = '0;
    case (address)
      STATUS_ADDR: begin
        w_rdata[ST_EMPTY]               = w_empty;
        w_rdata[ST_FULL]                = w_full;
        w_rdata[ST_OVF]                 = r_overflow;
        w_rdata[ST_BUSY]                = r_out_valid;
        w_rdata[ST_CNT_LSB +: CNT_W]    = w_count;
      end
      CONTROL_ADDR: w_rdata[CT_EN] = r_enable;
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_enable    <= 1'b1;
    end else begin
      r_readdata <= w_rdata;
      // A beat already on the link is held until the router takes it.
      if (w_load) begin
        r_out_data  <= w_head;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_push && w_full)  r_overflow <= 1'b1;
      else if (w_ovf_clr)    r_overflow <= 1'b0;
      if (w_wr && (address == CONTROL_ADDR)) r_enable <= writedata[CT_EN];
    end
  end

  assign readdata  = r_readdata;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_noc_output_data_tx.sv
// Directed bench for noc_output_data_tx with a queue-based reference model checked every cycle.
module tb_noc_output_data_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  noc_output_data_tx #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a plain queue, the link register a pair of variables.
  logic [31:0] m_q[$];
  logic        m_ov  = 1'b0;
  logic [31:0] m_od  = '0;
  logic [31:0] m_rd  = '0;
  logic        m_ovf = 1'b0;
  logic        m_en  = 1'b1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_ov = 1'b0; m_od = '0; m_rd = '0; m_ovf = 1'b0; m_en = 1'b1;
    end else begin
      bit wr, was_full, flush, load;
      int n;
      n        = m_q.size();
      wr       = chipselect && !write_n;
      was_full = (n == DEPTH);
      flush    = wr && address == 2'd2 && writedata[1];
      case (address)
        2'd1:    m_rd = (n * 256) + (m_ov ? 8 : 0) + (m_ovf ? 4 : 0)
                        + (was_full ? 2 : 0) + (n == 0 ? 1 : 0);
        2'd2:    m_rd = {31'd0, m_en};
        default: m_rd = 32'd0;
      endcase
      load = m_en && n > 0 && (!m_ov || out_ready) && !flush;
      if (load) begin
        m_od = m_q.pop_front();
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wr && address == 2'd0) begin
        if (was_full) m_ovf = 1'b1;
        else          m_q.push_back(writedata);
      end
      if (wr && address == 2'd1 && writedata[2]) m_ovf = 1'b0;
      if (wr && address == 2'd2) begin
        m_en = writedata[0];
        if (flush) m_q.delete();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      check("model_out_data", out_data, m_od);
      check("model_readdata", readdata, m_rd);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  initial begin
    logic [31:0] v;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    rd(2'd1, v);
    check("rst_status", v, 32'h0000_0001);
    rd(2'd2, v);
    check("rst_control", v, 32'h0000_0001);

    out_ready = 1'b1;
    wr(2'd0, 32'hA5A5_0001);
    check("single_not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data", out_data, 32'hA5A5_0001);
    @(negedge clk);
    check("single_drop", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(2'd0, 32'h100 + i);
    rd(2'd1, v);
    check("full_status", v, 32'h0000_080A);
    wr(2'd0, 32'h109);
    rd(2'd1, v);
    check("ovf_status", v, 32'h0000_080E);
    check("full_hold_data", out_data, 32'h100);

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_data", out_data, 32'h100 + i);
      @(negedge clk);
    end
    check("drain_done", {31'd0, out_valid}, 32'd0);
    rd(2'd1, v);
    check("drain_status", v, 32'h0000_0005);
    wr(2'd1, 32'h4);
    rd(2'd1, v);
    check("ovf_cleared", v, 32'h0000_0001);

    wr(2'd2, 32'h0);
    for (int i = 0; i < 3; i++) wr(2'd0, 32'h200 + i);
    check("dis_no_valid", {31'd0, out_valid}, 32'd0);
    rd(2'd1, v);
    check("dis_status", v, 32'h0000_0300);
    wr(2'd2, 32'h1);
    repeat (6) @(negedge clk);
    rd(2'd1, v);
    check("en_drained", v, 32'h0000_0001);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h300 + i);
    wr(2'd2, 32'h3);
    rd(2'd1, v);
    check("flush_status", v, 32'h0000_0009);
    check("flush_hold_data", out_data, 32'h300);
    rd(2'd2, v);
    check("flush_enable", v, 32'h0000_0001);
    repeat (2) @(negedge clk);
    check("flush_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_beat_done", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(2'd0, 32'h400 + i);
    out_ready = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_count", 32'(dut.w_count), 32'd0);
    check("arst_data", out_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd1, v);
    check("arst_status", v, 32'h0000_0001);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
